alarm_scheduler: RTL

Multi-channel countdown scheduler that time-shares one W-bit decrementer among N_CH independent alarm channels. Each channel has SET/RUN/PAUSE/BEEP behaviour driven by a valid/ready command port. A prescaler generates a tick; the scheduler then sweeps the channels round-robin, one per cycle, through the shared decrementer. It sits between the front-panel command decoder and the display/buzzer logic.

---
 rtl/alarm_scheduler.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/alarm_scheduler.sv
// alarm_scheduler: N_CH countdown alarms sharing one W-bit decrementer.
// A prescaler produces a tick every TICK_DIV cycles; the following N_CH
// cycles form a sweep that services channel k in sweep cycle k. Commands
// are accepted only outside the sweep, so they never race the decrementer.
//
// Per-channel state table:
//   state    | meaning
//   ST_SET   | loaded or cleared, not counting
//   ST_RUN   | counting down once per tick (count >= 1)
//   ST_PAUSE | counting suspended, count held
//   ST_BEEP  | count reached 0, alarm flag raised, waiting for ack
//
// Sweep controller table:
//   state    | meaning
//   SW_IDLE  | waiting for tick, command port open
//   SW_BUSY  | servicing channel idx_q, command port closed
module alarm_scheduler #(
  parameter  int N_CH     = 4,
  parameter  int W        = 9,
  parameter  int TICK_DIV = 8,
  localparam int CHW      = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [CHW-1:0]  cmd_ch,
  input  logic [W-1:0]    cmd_value,
  input  logic [N_CH-1:0] ack,
  output logic [N_CH-1:0] alarm,
  output logic            beep,
  input  logic [CHW-1:0]  rd_ch,
  output logic [W-1:0]    rd_time,
  output logic [1:0]      rd_state
);

  typedef enum logic [1:0] {
    ST_SET   = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_BEEP  = 2'd3
  } ch_state_e;

  typedef enum logic {
    SW_IDLE = 1'b0,
    SW_BUSY = 1'b1
  } sweep_state_e;

  localparam logic [1:0] OP_LOAD  = 2'd0;
  localparam logic [1:0] OP_START = 2'd1;
  localparam logic [1:0] OP_PAUSE = 2'd2;
  localparam logic [1:0] OP_CLEAR = 2'd3;

  logic [PW-1:0]   presc_q, presc_d;
  logic            tick;
  sweep_state_e    sweep_q, sweep_d;
  logic [CHW-1:0]  idx_q, idx_d;

  logic [W-1:0]    count_q [N_CH];
  logic [W-1:0]    count_d [N_CH];
  ch_state_e       state_q [N_CH];
  ch_state_e       state_d [N_CH];
  logic [N_CH-1:0] alarm_q, alarm_d;

  logic            beep_q, beep_d;
  logic [W-1:0]    rd_time_q, rd_time_d;
  ch_state_e       rd_state_q, rd_state_d;

  logic [W-1:0]    sel_count;
  logic [W-1:0]    dec;
  logic            cmd_fire;

  assign cmd_ready = (sweep_q == SW_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign alarm     = alarm_q;
  assign beep      = beep_q;
  assign rd_time   = rd_time_q;
  assign rd_state  = rd_state_q;

  // Prescaler wrap and tick detection.
  always_comb begin
    tick    = (presc_q == PW'(TICK_DIV - 1));
    presc_d = tick ? '0 : presc_q + PW'(1);
  end

  // Sweep controller: one channel per cycle for N_CH cycles after a tick.
  always_comb begin
    sweep_d = sweep_q;
    idx_d   = idx_q;
    case (sweep_q)
      SW_IDLE: begin
        if (tick) begin
          sweep_d = SW_BUSY;
          idx_d   = '0;
        end
      end
      SW_BUSY: begin
        if (idx_q == CHW'(N_CH - 1)) begin
          sweep_d = SW_IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + CHW'(1);
        end
      end
      default: begin
        sweep_d = SW_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Shared decrementer: select the serviced channel's count and subtract one.
  always_comb begin
    sel_count = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (idx_q == CHW'(i)) begin
        sel_count = count_q[i];
      end
    end
    dec = sel_count - W'(1);
  end

  // Channel next state. Later assignments take priority: ack is applied
  // first, so sweep expiry, START-to-BEEP and LOAD/CLEAR override it.
  always_comb begin
    count_d = count_q;
    state_d = state_q;
    alarm_d = alarm_q;

    for (int i = 0; i < N_CH; i++) begin
      if (ack[i]) begin
        alarm_d[i] = 1'b0;
        if (state_q[i] == ST_BEEP) begin
          state_d[i] = ST_SET;
        end
      end
    end

    if (sweep_q == SW_BUSY) begin
      for (int i = 0; i < N_CH; i++) begin
        if ((idx_q == CHW'(i)) && (state_q[i] == ST_RUN)) begin
          count_d[i] = dec;
          if (dec == '0) begin
            state_d[i] = ST_BEEP;
            alarm_d[i] = 1'b1;
          end
        end
      end
    end

    // Out-of-range channel numbers match no index and are dropped.
    if (cmd_fire) begin
      for (int i = 0; i < N_CH; i++) begin
        if (cmd_ch == CHW'(i)) begin
          case (cmd_op)
            OP_LOAD: begin
              count_d[i] = cmd_value;
              state_d[i] = ST_SET;
              alarm_d[i] = 1'b0;
            end
            OP_START: begin
              if ((state_q[i] == ST_SET) || (state_q[i] == ST_PAUSE)) begin
                if (count_q[i] != '0) begin
                  state_d[i] = ST_RUN;
                end else begin
                  state_d[i] = ST_BEEP;
                  alarm_d[i] = 1'b1;
                end
              end
            end
            OP_PAUSE: begin
              if (state_q[i] == ST_RUN) begin
                state_d[i] = ST_PAUSE;
              end
            end
            OP_CLEAR: begin
              count_d[i] = '0;
              state_d[i] = ST_SET;
              alarm_d[i] = 1'b0;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Readback mux and buzzer, registered one cycle behind channel state.
  always_comb begin
    rd_time_d  = '0;
    rd_state_d = ST_SET;
    for (int i = 0; i < N_CH; i++) begin
      if (rd_ch == CHW'(i)) begin
        rd_time_d  = count_q[i];
        rd_state_d = state_q[i];
      end
    end
    beep_d = |alarm_q;
  end

  // Control registers: prescaler and sweep controller.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
      sweep_q <= SW_IDLE;
      idx_q   <= '0;
    end else begin
      presc_q <= presc_d;
      sweep_q <= sweep_d;
      idx_q   <= idx_d;
    end
  end

  // Channel registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CH; i++) begin
        count_q[i] <= '0;
        state_q[i] <= ST_SET;
      end
      alarm_q <= '0;
    end else begin
      for (int i = 0; i < N_CH; i++) begin
        count_q[i] <= count_d[i];
        state_q[i] <= state_d[i];
      end
      alarm_q <= alarm_d;
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      beep_q     <= 1'b0;
      rd_time_q  <= '0;
      rd_state_q <= ST_SET;
    end else begin
      beep_q     <= beep_d;
      rd_time_q  <= rd_time_d;
      rd_state_q <= rd_state_d;
    end
  end

endmodule
